barrel_shift_pipe_8b: RTL and testbench

- Registered front/back end for the combinational 8-bit rotate barrel shifter.
- Accepts rotate requests over a valid/ready handshake and buffers them in a small FIFO.
- Drives the FIFO head onto the shifter inputs and captures the shifter result into a registered output stage with its own valid/ready handshake.
- Lets the shifter sit between pipelined producers and consumers without a combinational in-to-out path.

---
 rtl/barrel_shift_pipe_8b.sv | 98 +++++++++
 tb/tb_barrel_shift_pipe_8b.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/barrel_shift_pipe_8b.sv
// Registered FIFO front end and output register around an external combinational 8-bit rotate shifter.
// Optional completed-result counter (out_cnt) enabled by defining SHIFT_PIPE_CNT_EN.
module barrel_shift_pipe_8b #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic        in_lr,
  input  logic [2:0]  in_amt,
  output logic [7:0]  sh_a,
  output logic        sh_lr,
  output logic [2:0]  sh_amt,
  input  logic [7:0]  sh_y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data
`ifdef SHIFT_PIPE_CNT_EN
  ,
  output logic [15:0] out_cnt
`endif
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [11:0]       r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_out_valid;
  logic [7:0]        r_out_data;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_cap;
  logic [11:0]       w_head;

  assign w_full   = (r_count == FULL_CNT);
  assign w_empty  = (r_count == '0);
  assign in_ready = !w_full;
  assign w_push   = in_valid && !w_full;
  assign w_cap    = !w_empty && (!r_out_valid || out_ready);

  // Head is forced to zero when empty so the shifter inputs never show stale entries.
  assign w_head = w_empty ? 12'h000 : r_mem[r_rd_ptr];
  assign {sh_a, sh_lr, sh_amt} = w_head;

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {in_a, in_lr, in_amt};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_cap)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_cap})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= 8'h00;
    end else if (w_cap) begin
      r_out_valid <= 1'b1;
      r_out_data  <= sh_y;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef SHIFT_PIPE_CNT_EN
  logic [15:0] r_out_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         r_out_cnt <= 16'h0000;
    else if (r_out_valid && out_ready) r_out_cnt <= r_out_cnt + 16'h0001;
  end

  assign out_cnt = r_out_cnt;
`endif

endmodule

// File: tb/tb_barrel_shift_pipe_8b.sv
// Bench for barrel_shift_pipe_8b: behavioural shifter on sh_*, queue scoreboard checked at each output handshake.
module tb_barrel_shift_pipe_8b;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic        in_lr;
  logic [2:0]  in_amt;
  logic [7:0]  sh_a;
  logic        sh_lr;
  logic [2:0]  sh_amt;
  logic [7:0]  sh_y;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
`ifdef SHIFT_PIPE_CNT_EN
  logic [15:0] out_cnt;
`endif

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          pop_total = 0;
  logic [7:0]  sb [$];
  int          pop_cyc_q [$];

  barrel_shift_pipe_8b #(.DEPTH(4), .ADDR_W(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_lr     (in_lr),
    .in_amt    (in_amt),
    .sh_a      (sh_a),
    .sh_lr     (sh_lr),
    .sh_amt    (sh_amt),
    .sh_y      (sh_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef SHIFT_PIPE_CNT_EN
    ,
    .out_cnt   (out_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Behavioural shifter, bit-by-bit so it differs in form from the expected-value model.
  always_comb begin
    sh_y = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (sh_lr) sh_y[(i + int'(sh_amt)) % 8] = sh_a[i];
      else       sh_y[i] = sh_a[(i + int'(sh_amt)) % 8];
    end
  end

  function automatic logic [7:0] rot_model(input logic [7:0] a, input logic lr, input logic [2:0] amt);
    logic [15:0] d;
    d = {a, a};
    if (lr) begin
      d = d << amt;
      return d[15:8];
    end
    d = d >> amt;
    return d[7:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: push on accepted input, pop and compare on output handshake.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) begin
        check("pop_has_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) check("out_data_order", out_data, sb.pop_front());
        pop_cyc_q.push_back(cyc);
        pop_total++;
      end
      if (in_valid && in_ready) sb.push_back(rot_model(in_a, in_lr, in_amt));
    end
  end

  task automatic send_one(input logic [7:0] a, input logic lr, input logic [2:0] amt,
                          input logic [7:0] exp, input string tag);
    out_ready = 1'b1;
    in_a = a; in_lr = lr; in_amt = amt; in_valid = 1'b1;
    @(negedge clk);
    check({tag, "_in_ready"}, in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_sh_a_visible"}, sh_a, a);
    check({tag, "_valid_not_yet"}, out_valid, 1'b0);
    @(negedge clk);
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_data"}, out_data, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    int acc;
    int n;
    logic [7:0] first_exp;

    reset = 1'b1; in_valid = 1'b0; in_a = 8'h00; in_lr = 1'b0; in_amt = 3'd0; out_ready = 1'b0;
    #2;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_sh", {sh_a, sh_lr, sh_amt}, 12'h000);
`ifdef SHIFT_PIPE_CNT_EN
    check("rst_out_cnt", out_cnt, 16'h0000);
`endif
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    send_one(8'h96, 1'b0, 3'd1, 8'h4B, "ror1");
    send_one(8'h96, 1'b0, 3'd0, 8'h96, "ror0");
    send_one(8'h96, 1'b1, 3'd3, 8'hB4, "rol3");
    send_one(8'h01, 1'b1, 3'd7, 8'h80, "rol7");

    // Backpressure: DEPTH entries plus the output register fill up.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    acc = 0;
    first_exp = rot_model(8'h21, 1'b0, 3'd1);
    for (int c = 0; c < 10; c++) begin
      in_a   = 8'h21 + 8'(acc * 37);
      in_lr  = acc[0];
      in_amt = 3'(acc + 1);
      @(negedge clk);
      if (in_ready) acc++;
      if (c >= 2) check("stall_data_stable", out_data, first_exp);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("full_accept_count", acc, 5);
    check("full_in_ready_low", in_ready, 1'b0);
    check("stall_valid", out_valid, 1'b1);
    check("stall_data", out_data, first_exp);
    pop_cyc_q.delete();
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("drain_count", pop_cyc_q.size(), 5);
    if (pop_cyc_q.size() == 5) check("drain_back_to_back", pop_cyc_q[4] - pop_cyc_q[0], 4);
    check("drain_sb_empty", sb.size(), 0);

    // Streaming with out_ready high.
    pop_cyc_q.delete();
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_a     = 8'($urandom);
      in_lr    = (i >= 8);
      in_amt   = 3'(i);
      @(negedge clk);
      check("stream_in_ready", in_ready, 1'b1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("stream_count", pop_cyc_q.size(), 16);
    if (pop_cyc_q.size() == 16) check("stream_consecutive", pop_cyc_q[15] - pop_cyc_q[0], 15);
    check("stream_sb_empty", sb.size(), 0);

    // Reset with requests in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_a = 8'hC0 + 8'(i); in_lr = 1'b1; in_amt = 3'(i + 2);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #3 reset = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_out_data", out_data, 8'h00);
    check("midrst_sh_a", sh_a, 8'h00);
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    pop_cyc_q.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("postrst_no_stale", out_valid, 1'b0);
    end
    check("postrst_no_pop", pop_cyc_q.size(), 0);
`ifdef SHIFT_PIPE_CNT_EN
    check("postrst_out_cnt", out_cnt, 16'h0000);

    // Preload the counter to 16'hFFFF, then one more handshake wraps it.
    @(posedge clk); #1;
    n = 0;
    in_a = 8'h5A; in_lr = 1'b0; in_amt = 3'd3; in_valid = 1'b1;
    for (int c = 0; c < 70000 && n < 65535; c++) begin
      @(negedge clk);
      if (in_valid && in_ready) n++;
      @(posedge clk); #1;
      if (n == 65535) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("cnt_preload_pushes", n, 65535);
    check("cnt_ffff", out_cnt, 16'hFFFF);
    send_one(8'h3C, 1'b1, 3'd2, 8'hF0, "cnt_last");
    #1;
    check("cnt_wrap", out_cnt, 16'h0000);
`endif

    repeat (2) @(posedge clk);
    #1;
    check("final_sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
